// File: rtl/clock_pkg.sv
// Shared constants for the clock-digit counters: per-field moduli and BCD digit width.
// Pure declarations; no logic, no latency, no flow control.
package clock_pkg;
  localparam int SEC_MOD  = 60;
  localparam int MIN_MOD  = 60;
  localparam int HOUR_MOD = 24;
  localparam int BCD_W    = 4;
endpackage

// File: rtl/bin2bcd.sv
// Combinational 0..99 binary to two-digit BCD split; zero latency, no backpressure.
module bin2bcd
  import clock_pkg::*;
(
  input  logic [6:0]       bin,
  output logic [BCD_W-1:0] tens,
  output logic [BCD_W-1:0] ones
);
  // Inputs never exceed 99, so both quotient and remainder fit a digit.
  assign tens = BCD_W'(bin / 7'd10);
  assign ones = BCD_W'(bin % 7'd10);
endmodule

// File: rtl/time_counter.sv
// Modulo up/down counter with parallel load, registered BCD digits and cascade carry.
// One-cycle update latency on count/digits/load_err, combinational tc; no backpressure.
module time_counter
  import clock_pkg::*;
#(
  parameter int MODULUS = 60,
  parameter int WIDTH   = 6,
  parameter int INIT    = 0
) (
  input  logic             clk,
  input  logic             fin,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] count,
  output logic [BCD_W-1:0] tens,
  output logic [BCD_W-1:0] ones,
  output logic             tc,
  output logic             load_err
);
  if (MODULUS > 100 || MODULUS < 2 || (2 ** WIDTH) < MODULUS || INIT >= MODULUS || INIT < 0)
  begin : g_bad_params
    $error("time_counter: illegal MODULUS/WIDTH/INIT combination");
  end

  localparam logic [WIDTH-1:0] MAX_V     = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH:0]   MOD_V     = (WIDTH + 1)'(MODULUS);
  localparam logic [WIDTH-1:0] INIT_V    = WIDTH'(INIT);
  localparam logic [BCD_W-1:0] INIT_TENS = BCD_W'(INIT / 10);
  localparam logic [BCD_W-1:0] INIT_ONES = BCD_W'(INIT % 10);

  logic [WIDTH-1:0] count_nxt;
  logic [BCD_W-1:0] tens_nxt;
  logic [BCD_W-1:0] ones_nxt;
  logic             err_nxt;
  logic             at_max;
  logic             at_zero;

  assign at_max  = (count == MAX_V);
  assign at_zero = (count == '0);
  assign tc      = en & ~load & ~fin & ((up & at_max) | (~up & at_zero));

  // Reset is applied in the register block, so this only covers load > en > hold.
  always_comb begin
    count_nxt = count;
    err_nxt   = 1'b0;
    if (load) begin
      if ({1'b0, din} < MOD_V) begin
        count_nxt = din;
      end else begin
        err_nxt = 1'b1;
      end
    end else if (en) begin
      if (up) begin
        count_nxt = at_max ? '0 : count + WIDTH'(1);
      end else begin
        count_nxt = at_zero ? MAX_V : count - WIDTH'(1);
      end
    end
  end

  // Digits derive from the next count so they land on the same edge as count.
  bin2bcd u_bin2bcd (
    .bin  (7'(count_nxt)),
    .tens (tens_nxt),
    .ones (ones_nxt)
  );

  always_ff @(posedge clk) begin
    if (fin) begin
      count    <= INIT_V;
      tens     <= INIT_TENS;
      ones     <= INIT_ONES;
      load_err <= 1'b0;
    end else begin
      count    <= count_nxt;
      tens     <= tens_nxt;
      ones     <= ones_nxt;
      load_err <= err_nxt;
    end
  end
endmodule

// File: tb/tb_time_counter.sv
// Minute counter cascaded into an hour counter, checked against a modular-arithmetic model.
module tb_time_counter;
  import clock_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       fin = 1'b1, en = 1'b0, up = 1'b0, load = 1'b0;
  logic [5:0] din = '0;
  logic [5:0] count;
  logic [3:0] tens, ones;
  logic       tc, load_err;

  logic       hr_load = 1'b0;
  logic [4:0] hr_din = '0;
  logic [4:0] hr_count;
  logic [3:0] hr_tens, hr_ones;
  logic       hr_tc, hr_err;

  time_counter dut (
    .clk(clk), .fin(fin), .en(en), .up(up), .load(load), .din(din),
    .count(count), .tens(tens), .ones(ones), .tc(tc), .load_err(load_err)
  );

  time_counter #(.MODULUS(HOUR_MOD), .WIDTH(5), .INIT(0)) hr (
    .clk(clk), .fin(fin), .en(tc), .up(up), .load(hr_load), .din(hr_din),
    .count(hr_count), .tens(hr_tens), .ones(hr_ones), .tc(hr_tc), .load_err(hr_err)
  );

  typedef struct {
    int tc, cnt, err;
    int htc, hcnt, herr;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   m_min = 0;
  int   m_hr = 0;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endtask

  // One clock of stimulus: drive inputs, predict the cycle, queue the prediction.
  task automatic step(input bit f, input bit e, input bit u, input bit l, input int d,
                      input bit hl, input int hd);
    exp_t x;
    @(negedge clk);
    fin = f; en = e; up = u; load = l; din = 6'(d); hr_load = hl; hr_din = 5'(hd);
    x.tc  = int'(e && !l && !f && (u ? m_min == MIN_MOD - 1 : m_min == 0));
    x.htc = int'(x.tc != 0 && !hl && !f && (u ? m_hr == HOUR_MOD - 1 : m_hr == 0));
    x.err = 0;
    x.herr = 0;
    x.cnt = m_min;
    x.hcnt = m_hr;
    if (f) begin
      x.cnt = 0;
      x.hcnt = 0;
    end else begin
      if (l) begin
        if (d < MIN_MOD) x.cnt = d; else x.err = 1;
      end else if (e) begin
        x.cnt = u ? (m_min + 1) % MIN_MOD : (m_min + MIN_MOD - 1) % MIN_MOD;
      end
      if (hl) begin
        if (hd < HOUR_MOD) x.hcnt = hd; else x.herr = 1;
      end else if (x.tc != 0) begin
        x.hcnt = u ? (m_hr + 1) % HOUR_MOD : (m_hr + HOUR_MOD - 1) % HOUR_MOD;
      end
    end
    m_min = x.cnt;
    m_hr  = x.hcnt;
    q.push_back(x);
  endtask

  // Monitor: tc mid-cycle, registered outputs just after the following edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #3;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("tc", int'(tc), e.tc);
        chk("hr_tc", int'(hr_tc), e.htc);
        @(posedge clk);
        #1;
        chk("count", int'(count), e.cnt);
        chk("tens", int'(tens), e.cnt / 10);
        chk("ones", int'(ones), e.cnt % 10);
        chk("load_err", int'(load_err), e.err);
        chk("hr_count", int'(hr_count), e.hcnt);
        chk("hr_tens", int'(hr_tens), e.hcnt / 10);
        chk("hr_ones", int'(hr_ones), e.hcnt % 10);
        chk("hr_load_err", int'(hr_err), e.herr);
      end
    end
  end

  initial begin
    // Reset, then a full upward lap plus one.
    repeat (2) step(1, 0, 0, 0, 0, 0, 0);
    repeat (61) step(0, 1, 1, 0, 0, 0, 0);
    // Borrow from zero.
    step(0, 0, 0, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0);
    // Load wins over count enable.
    step(0, 1, 1, 1, 42, 0, 0);
    // Rejected load keeps value, error pulse lasts one cycle.
    step(0, 0, 0, 1, 17, 0, 0);
    step(0, 1, 1, 1, 63, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 60, 1, 24);
    step(0, 0, 0, 0, 0, 0, 0);
    // Reset at the wrap point suppresses tc and the wrap.
    step(0, 0, 0, 1, 59, 0, 0);
    step(1, 1, 1, 0, 0, 0, 0);
    // 23:59 -> 00:00 rollover across the cascade, then 00:00 -> 23:59 going down.
    step(0, 0, 0, 1, 59, 1, 23);
    step(0, 1, 1, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    // Random traffic.
    repeat (1500) begin
      step($urandom_range(49, 0) == 0, $urandom_range(3, 0) != 0, $urandom_range(4, 0) != 0,
           $urandom_range(7, 0) == 0, int'($urandom_range(63, 0)),
           $urandom_range(39, 0) == 0, int'($urandom_range(31, 0)));
    end
    step(0, 0, 0, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    chk("queue_drained", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
